// File: rtl/encoder8_3_pkg.sv
// Shared constants, output bundle type and empty-encoding helper for the 8-to-3 encoder.
// Used by encoder8_3_core and by encoder8_3 (with or without ENCODER8_3_REG_EN).
package encoder8_3_pkg;

  localparam int DATA_W = 8;
  localparam int IDX_W  = 3;

  localparam logic [IDX_W-1:0] IDX_MAX        = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] EMPTY_CODE_DEF = 3'd0;
  localparam logic [IDX_W-1:0] EMPTY_NEXT     = 3'd0;
  localparam logic             EMPTY_NEXT_OK  = 1'b1;

  typedef struct packed {
    logic [IDX_W-1:0] high;
    logic             any;
    logic [IDX_W-1:0] low;
    logic             full;
    logic [IDX_W-1:0] next;
    logic             nextOk;
  } enc_out_t;

  // An empty vector reports the configured code for both indices and slot 0 as free.
  function automatic enc_out_t emptyEncoding(input logic [IDX_W-1:0] code);
    enc_out_t e;
    e.high   = code;
    e.any    = 1'b0;
    e.low    = code;
    e.full   = 1'b0;
    e.next   = EMPTY_NEXT;
    e.nextOk = EMPTY_NEXT_OK;
    return e;
  endfunction

endpackage

// File: rtl/encoder8_3_core.sv
// Combinational priority logic: highest/lowest set bit, any/full flags and the
// next free slot above the highest occupied one.
module encoder8_3_core
  import encoder8_3_pkg::*;
#(
  parameter logic [IDX_W-1:0] EMPTY_CODE = EMPTY_CODE_DEF
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [IDX_W-1:0]  o_high,
  output logic              o_any,
  output logic [IDX_W-1:0]  o_low,
  output logic              o_full,
  output logic [IDX_W-1:0]  o_next,
  output logic              o_nextOk
);

  logic [IDX_W-1:0] w_high;
  logic [IDX_W-1:0] w_low;
  logic             w_any;
  enc_out_t         w_empty;

  assign w_any   = |i_data;
  assign w_empty = emptyEncoding(EMPTY_CODE);

  // Upward scan lets the topmost 1 win; downward scan lets the bottom 1 win.
  always_comb begin
    w_high = '0;
    w_low  = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i_data[i]) w_high = IDX_W'(i);
    end
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (i_data[i]) w_low = IDX_W'(i);
    end
  end

  // The top slot saturates instead of wrapping back to slot 0.
  always_comb begin
    o_high   = w_empty.high;
    o_low    = w_empty.low;
    o_any    = 1'b0;
    o_full   = 1'b0;
    o_next   = w_empty.next;
    o_nextOk = w_empty.nextOk;
    if (w_any) begin
      o_high = w_high;
      o_low  = w_low;
      o_any  = 1'b1;
      o_full = &i_data;
      if (w_high == IDX_MAX) begin
        o_next   = IDX_MAX;
        o_nextOk = 1'b0;
      end else begin
        o_next   = w_high + 1'b1;
        o_nextOk = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder8_3.sv
// 8-to-3 priority encoder top. Define ENCODER8_3_REG_EN for a one-cycle registered
// output stage with synchronous reset; otherwise outputs are purely combinational.
module encoder8_3
  import encoder8_3_pkg::*;
#(
  parameter logic [IDX_W-1:0] EMPTY_CODE = EMPTY_CODE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  output logic [IDX_W-1:0]  O,
  output logic              V,
  output logic [IDX_W-1:0]  L,
  output logic              F,
  output logic [IDX_W-1:0]  N,
  output logic              NV
);

  logic [IDX_W-1:0] w_high;
  logic             w_any;
  logic [IDX_W-1:0] w_low;
  logic             w_full;
  logic [IDX_W-1:0] w_next;
  logic             w_nextOk;
  enc_out_t         w_enc;
  enc_out_t         w_out;

  encoder8_3_core #(
    .EMPTY_CODE(EMPTY_CODE)
  ) u_core (
    .i_data  (data),
    .o_high  (w_high),
    .o_any   (w_any),
    .o_low   (w_low),
    .o_full  (w_full),
    .o_next  (w_next),
    .o_nextOk(w_nextOk)
  );

  assign w_enc = '{high: w_high, any: w_any, low: w_low,
                   full: w_full, next: w_next, nextOk: w_nextOk};

`ifdef ENCODER8_3_REG_EN
  enc_out_t r_enc;

  // Reset wins over data on the same edge and loads the empty encoding.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_enc <= emptyEncoding(EMPTY_CODE);
    end else begin
      r_enc <= w_enc;
    end
  end

  assign w_out = r_enc;
`else
  logic w_unused;

  assign w_unused = ^{clk, reset};
  assign w_out    = w_enc;
`endif

  assign O  = w_out.high;
  assign V  = w_out.any;
  assign L  = w_out.low;
  assign F  = w_out.full;
  assign N  = w_out.next;
  assign NV = w_out.nextOk;

endmodule

// File: tb/tb_encoder8_3.sv
// Scoreboard bench for encoder8_3: stimulus pushes arithmetic-model expectations,
// a negedge monitor pops and compares them. Honours ENCODER8_3_REG_EN latency.
module tb_encoder8_3;

`ifdef ENCODER8_3_REG_EN
  localparam bit REG_MODE = 1'b1;
  localparam int LATENCY  = 1;
`else
  localparam bit REG_MODE = 1'b0;
  localparam int LATENCY  = 0;
`endif
  localparam logic [2:0] EMPTY = 3'd0;

  typedef struct {
    logic [7:0] data;
    logic       rst;
    int         target;
    logic [2:0] o;
    logic       v;
    logic [2:0] l;
    logic       f;
    logic [2:0] n;
    logic       nv;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic [2:0] O, L, N;
  logic       V, F, NV;

  int   cycleCount = 0;
  int   compared   = 0;
  int   mismatched = 0;
  exp_t sbQueue[$];

  encoder8_3 #(
    .EMPTY_CODE(EMPTY)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .data (data),
    .O    (O),
    .V    (V),
    .L    (L),
    .F    (F),
    .N    (N),
    .NV   (NV)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Highest set bit = floor(log2(d)); lowest set bit = log2 of the isolated low bit.
  function automatic exp_t model(input logic [7:0] d, input logic r);
    exp_t e;
    int   dv;
    int   hi;
    dv     = int'(d);
    e.data = d;
    e.rst  = r;
    e.target = 0;
    if ((REG_MODE && r) || dv == 0) begin
      e.o = EMPTY; e.l = EMPTY; e.v = 1'b0; e.f = 1'b0; e.n = 3'd0; e.nv = 1'b1;
    end else begin
      hi   = $clog2(dv + 1) - 1;
      e.o  = 3'(hi);
      e.l  = 3'($clog2(dv & -dv));
      e.v  = 1'b1;
      e.f  = (dv == 255);
      e.n  = (hi < 7) ? 3'(hi + 1) : 3'd7;
      e.nv = (hi < 7);
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [7:0] d, input logic r);
    exp_t e;
    @(posedge clk);
    #1;
    data  = d;
    reset = r;
    e = model(d, r);
    e.target = cycleCount + LATENCY;
    sbQueue.push_back(e);
  endtask

  task automatic compareField(input string name, input logic [7:0] d,
                              input logic [2:0] act, input logic [2:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s data=%02h got=%0d expected=%0d", name, d, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compareField("O",  e.data, O,          e.o);
    compareField("V",  e.data, {2'b0, V},  {2'b0, e.v});
    compareField("L",  e.data, L,          e.l);
    compareField("F",  e.data, {2'b0, F},  {2'b0, e.f});
    compareField("N",  e.data, N,          e.n);
    compareField("NV", e.data, {2'b0, NV}, {2'b0, e.nv});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbQueue.size() > 0 && sbQueue[0].target <= cycleCount) begin
        e = sbQueue.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : stimulus
    logic [7:0] directed[$];
    int waitCycles;
    reset = 1'b1;
    data  = 8'h00;

    applyStimulus(8'h5A, 1'b1);
    applyStimulus(8'h00, 1'b1);

    directed = '{8'h00, 8'h01, 8'h07, 8'h80, 8'hFF, 8'h4A, 8'h26, 8'h7F, 8'h81};
    foreach (directed[i]) applyStimulus(directed[i], 1'b0);

    for (int d = 0; d < 256; d++) applyStimulus(8'(d), 1'b0);

    applyStimulus(8'h3C, 1'b0);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'hFF, 1'b0);
    applyStimulus(8'hFF, 1'b0);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0));
    end
    applyStimulus(8'h00, 1'b0);

    waitCycles = 0;
    while (sbQueue.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    @(posedge clk);
    if (sbQueue.size() > 0) begin
      mismatched++;
      $display("[TB] FAIL drain pending=%0d expected=0", sbQueue.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
